// File: rtl/regfile_param.sv
// regfile_param: parametrised 2R/2W register file (B wins collisions), optional registered reads/bypass/zero reg, sequenced clear sweep
module regfile_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int REG_RD   = 0,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] waddr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] waddr_b,
  input  logic [DATA_W-1:0] wdata_b,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_collide,
  output logic              wr_drop
);
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] cnt;
  logic zero_a, zero_b, ok_a, ok_b;
  assign zero_a = ZERO_REG != 0 && waddr_a == '0;
  assign zero_b = ZERO_REG != 0 && waddr_b == '0;
  assign ok_a = we_a && !busy && !zero_a;
  assign ok_b = we_b && !busy && !zero_b;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = state == IDLE ? (clr_req ? SWEEP : IDLE) : (cnt == ADDR_W'(DEPTH - 1) ? IDLE : SWEEP);
  always_comb busy = state == SWEEP;
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      cnt <= '0;
      wr_collide <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      if (busy) begin
        mem[cnt] <= '0;
        cnt <= cnt + 1'b1;
      end
      if (ok_a) mem[waddr_a] <= wdata_a;
      if (ok_b) mem[waddr_b] <= wdata_b;
      wr_collide <= ok_a && ok_b && waddr_a == waddr_b;
      wr_drop <= (busy && (we_a || we_b)) || (we_a && zero_a) || (we_b && zero_b);
    end
  for (genvar g = 0; g < 2; g++) begin : gen_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] nx, q;
    assign ra = g == 0 ? raddr1 : raddr2;
    always_comb nx = (ZERO_REG != 0 && ra == '0) ? '0 :
                     (BYPASS != 0 && ok_b && waddr_b == ra) ? wdata_b :
                     (BYPASS != 0 && ok_a && waddr_a == ra) ? wdata_a : mem[ra];
    if (REG_RD != 0) begin : gen_reg
      always_ff @(posedge clk)
        if (rst) q <= '0;
        else q <= nx;
    end else begin : gen_comb
      assign q = nx;
    end
  end
  assign rdata1 = gen_rd[0].q;
  assign rdata2 = gen_rd[1].q;
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: scoreboard bench driving four configurations of regfile_param with shared directed stimulus
module tb_regfile_param;
  logic clk = 0, rst = 1, we_a = 0, we_b = 0, clr_req = 0;
  logic [2:0] waddr_a = 0, waddr_b = 0, raddr1 = 0, raddr2 = 0;
  logic [7:0] wdata_a = 0, wdata_b = 0;
  logic [7:0] a_rd1, a_rd2, b_rd1, b_rd2, c_rd1, c_rd2, z_rd1, z_rd2;
  logic a_busy, a_col, a_drop, b_busy, b_col, b_drop, c_busy, c_col, c_drop, z_busy, z_col, z_drop;
  typedef struct {int cyc; int id; logic [7:0] val;} exp_t;
  exp_t q[$];
  int cyc = 0, checks = 0, errors = 0;
  string nm[10] = '{"a_rdata1", "a_rdata2", "a_busy", "a_wr_collide", "a_wr_drop", "regbyp_rdata1", "regnobyp_rdata1", "zero_rdata1", "zero_wr_drop", "zero_rdata2"};
  int lst[6] = '{0, 3, 4, 5, 6, 7};
  regfile_param #(.REG_RD(0), .BYPASS(1)) u_a (.clk(clk), .rst(rst), .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a), .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b), .raddr1(raddr1), .raddr2(raddr2), .rdata1(a_rd1), .rdata2(a_rd2), .clr_req(clr_req), .busy(a_busy), .wr_collide(a_col), .wr_drop(a_drop));
  regfile_param #(.REG_RD(1), .BYPASS(1)) u_b (.clk(clk), .rst(rst), .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a), .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b), .raddr1(raddr1), .raddr2(raddr2), .rdata1(b_rd1), .rdata2(b_rd2), .clr_req(clr_req), .busy(b_busy), .wr_collide(b_col), .wr_drop(b_drop));
  regfile_param #(.REG_RD(1), .BYPASS(0)) u_c (.clk(clk), .rst(rst), .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a), .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b), .raddr1(raddr1), .raddr2(raddr2), .rdata1(c_rd1), .rdata2(c_rd2), .clr_req(clr_req), .busy(c_busy), .wr_collide(c_col), .wr_drop(c_drop));
  regfile_param #(.ZERO_REG(1)) u_z (.clk(clk), .rst(rst), .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a), .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b), .raddr1(raddr1), .raddr2(raddr2), .rdata1(z_rd1), .rdata2(z_rd2), .clr_req(clr_req), .busy(z_busy), .wr_collide(z_col), .wr_drop(z_drop));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] get(int id);
    case (id)
      0: return a_rd1;
      1: return a_rd2;
      2: return {7'b0, a_busy};
      3: return {7'b0, a_col};
      4: return {7'b0, a_drop};
      5: return b_rd1;
      6: return c_rd1;
      7: return z_rd1;
      8: return {7'b0, z_drop};
      default: return z_rd2;
    endcase
  endfunction
  always @(negedge clk)
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].cyc == cyc) begin
        checks++;
        if (get(q[i].id) !== q[i].val) begin
          errors++;
          $display("FAIL %s at cycle %0d: got %h expected %h", nm[q[i].id], cyc, get(q[i].id), q[i].val);
        end
        q.delete(i);
      end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ex(int id, logic [7:0] v, int d);
    q.push_back('{cyc + d, id, v});
  endtask
  initial begin
    tick();
    tick();
    rst = 0;
    raddr1 = 0; raddr2 = 5;
    ex(0, 8'h00, 0); ex(1, 8'h00, 0); ex(2, 0, 0); ex(3, 0, 0); ex(4, 0, 0); ex(5, 8'h00, 0);
    tick();
    we_a = 1; waddr_a = 1; wdata_a = 8'hAA;
    tick();
    we_a = 0; we_b = 1; waddr_b = 2; wdata_b = 8'h55;
    tick();
    we_b = 0; raddr1 = 1; raddr2 = 2;
    ex(0, 8'hAA, 0); ex(1, 8'h55, 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      raddr1 = 3'(lst[i]);
      ex(0, 8'h00, 0);
      tick();
    end
    we_a = 1; waddr_a = 3; wdata_a = 8'h11; we_b = 1; waddr_b = 3; wdata_b = 8'h22; raddr1 = 3;
    ex(0, 8'h22, 0); ex(3, 1, 1); ex(4, 0, 1);
    tick();
    we_a = 0; we_b = 0;
    ex(0, 8'h22, 0); ex(3, 0, 1);
    tick();
    we_a = 1; waddr_a = 5; wdata_a = 8'h33; we_b = 1; waddr_b = 6; wdata_b = 8'h44;
    ex(3, 0, 1);
    tick();
    we_a = 0; we_b = 0; raddr1 = 5; raddr2 = 6;
    ex(0, 8'h33, 0); ex(1, 8'h44, 0);
    tick();
    we_a = 1; waddr_a = 4; wdata_a = 8'h5A; raddr1 = 4;
    ex(0, 8'h5A, 0); ex(5, 8'h5A, 1); ex(6, 8'h00, 1);
    tick();
    we_a = 0;
    ex(5, 8'h5A, 1); ex(6, 8'h5A, 1);
    tick();
    we_a = 1; waddr_a = 0; wdata_a = 8'hFF; raddr1 = 0;
    ex(7, 8'h00, 0); ex(0, 8'hFF, 0); ex(8, 1, 1); ex(4, 0, 1);
    tick();
    we_a = 0;
    ex(7, 8'h00, 0); ex(0, 8'hFF, 0); ex(8, 0, 1);
    tick();
    we_b = 1; waddr_b = 0; wdata_b = 8'h77; raddr2 = 0;
    ex(9, 8'h00, 0); ex(8, 1, 1);
    tick();
    we_b = 0;
    for (int i = 0; i < 4; i++) begin
      we_a = 1; waddr_a = 3'(2 * i); wdata_a = 8'hF0 + 8'(2 * i);
      we_b = 1; waddr_b = 3'(2 * i + 1); wdata_b = 8'hF0 + 8'(2 * i + 1);
      tick();
    end
    we_a = 0; we_b = 0;
    for (int i = 0; i < 4; i++) begin
      raddr1 = 3'(2 * i); raddr2 = 3'(2 * i + 1);
      ex(0, 8'hF0 + 8'(2 * i), 0); ex(1, 8'hF0 + 8'(2 * i + 1), 0);
      tick();
    end
    clr_req = 1;
    ex(2, 0, 0);
    tick();
    for (int j = 0; j < 8; j++) begin
      clr_req = j == 4;
      we_a = j == 6; waddr_a = 0; wdata_a = 8'h99;
      raddr1 = 3'(j);
      raddr2 = j == 0 ? 3'd7 : j == 6 ? 3'd0 : 3'(j - 1);
      ex(2, 1, 0);
      ex(0, 8'hF0 + 8'(j), 0);
      ex(1, j == 0 ? 8'hF7 : 8'h00, 0);
      if (j == 6) ex(4, 1, 1);
      tick();
    end
    clr_req = 0; we_a = 0;
    ex(2, 0, 0); ex(4, 0, 0);
    for (int i = 0; i < 4; i++) begin
      raddr1 = 3'(2 * i); raddr2 = 3'(2 * i + 1);
      ex(0, 8'h00, 0); ex(1, 8'h00, 0);
      tick();
    end
    we_a = 1; waddr_a = 6; wdata_a = 8'h66; we_b = 1; waddr_b = 7; wdata_b = 8'hF7;
    tick();
    we_a = 0; we_b = 0; clr_req = 1;
    tick();
    clr_req = 0;
    ex(2, 1, 0);
    tick();
    ex(2, 1, 0);
    tick();
    rst = 1; we_a = 1; we_b = 1; waddr_a = 5; waddr_b = 5; raddr1 = 7; raddr2 = 6;
    tick();
    rst = 0; we_a = 0; we_b = 0;
    ex(2, 0, 0); ex(3, 0, 0); ex(4, 0, 0); ex(5, 8'h00, 0); ex(0, 8'h00, 0); ex(1, 8'h00, 0);
    tick();
    we_a = 1; waddr_a = 7; wdata_a = 8'hC3;
    tick();
    we_a = 0;
    ex(0, 8'hC3, 0); ex(5, 8'hC3, 0); ex(2, 0, 0);
    tick();
    tick();
    tick();
    checks += 6;
    if (a_rd1 !== 8'hC3) begin errors++; $display("FAIL final a_rdata1: got %h expected c3", a_rd1); end
    if (a_rd2 !== 8'h00) begin errors++; $display("FAIL final a_rdata2: got %h expected 00", a_rd2); end
    if (b_rd1 !== 8'hC3) begin errors++; $display("FAIL final regbyp_rdata1: got %h expected c3", b_rd1); end
    if (c_rd1 !== 8'hC3) begin errors++; $display("FAIL final regnobyp_rdata1: got %h expected c3", c_rd1); end
    if (z_rd1 !== 8'hC3) begin errors++; $display("FAIL final zero_rdata1: got %h expected c3", z_rd1); end
    if (a_busy !== 1'b0) begin errors++; $display("FAIL final a_busy: got %b expected 0", a_busy); end
    foreach (q[i]) begin
      checks++;
      errors++;
      $display("FAIL %s: never compared, expected %h at cycle %0d", nm[q[i].id], q[i].val, q[i].cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
